// File: rtl/stream_mux_2x1_if.sv
// stream_mux_2x1_if: two input streams merged onto one tagged output stream
interface stream_mux_2x1_if #(parameter int DATA_WIDTH = 4);
  logic [DATA_WIDTH-1:0] in0;
  logic                  in0_valid;
  logic                  in0_ready;
  logic [DATA_WIDTH-1:0] in1;
  logic                  in1_valid;
  logic                  in1_ready;
  logic [DATA_WIDTH-1:0] out0;
  logic                  out_sel;
  logic                  out_valid;
  logic                  out_ready;
  modport master (
    output in0, in0_valid, in1, in1_valid, out_ready,
    input  in0_ready, in1_ready, out0, out_sel, out_valid
  );
  modport slave (
    input  in0, in0_valid, in1, in1_valid, out_ready,
    output in0_ready, in1_ready, out0, out_sel, out_valid
  );
endinterface

// File: rtl/stream_mux_2x1.sv
// stream_mux_2x1: registered 2:1 stream merge with burst-limited round-robin grant
module stream_mux_2x1 #(
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input logic clk,
  input logic rst_n,
  stream_mux_2x1_if.slave s
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MB = CW'(MAX_BURST);
  logic          last_sel;
  logic [CW-1:0] burst_cnt;
  logic          load, any, both, grant;
  assign load  = !s.out_valid || s.out_ready;
  assign any   = s.in0_valid || s.in1_valid;
  assign both  = s.in0_valid && s.in1_valid;
  // the burst limit only bites when both sides are competing
  assign grant = both ? ((burst_cnt < MB) ? last_sel : !last_sel) : s.in1_valid;
  assign s.in0_ready = load && s.in0_valid && !grant;
  assign s.in1_ready = load && s.in1_valid && grant;
  // reset state lets input 0 win the first contended cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s.out0      <= '0;
      s.out_sel   <= 1'b0;
      s.out_valid <= 1'b0;
      last_sel    <= 1'b1;
      burst_cnt   <= MB;
    end else if (load) begin
      s.out_valid <= any;
      if (any) begin
        s.out0    <= grant ? s.in1 : s.in0;
        s.out_sel <= grant;
        last_sel  <= grant;
        burst_cnt <= (grant != last_sel) ? CW'(1) : (burst_cnt == MB) ? MB : burst_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_stream_mux_2x1.sv
// tb_stream_mux_2x1: random and directed stimulus against a run-length arbitration model
module tb_stream_mux_2x1;
  localparam int DW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] d0, d1;
  logic v0, v1, ordy;
  int total = 0;
  int bad = 0;
  int mb[2] = '{4, 1};
  int mv[2], md[2], ms[2], last[2], run[2];
  always #5 clk = ~clk;
  stream_mux_2x1_if #(.DATA_WIDTH(DW)) b0 ();
  stream_mux_2x1_if #(.DATA_WIDTH(DW)) b1 ();
  assign b0.in0 = d0;
  assign b0.in1 = d1;
  assign b0.in0_valid = v0;
  assign b0.in1_valid = v1;
  assign b0.out_ready = ordy;
  assign b1.in0 = d0;
  assign b1.in1 = d1;
  assign b1.in0_valid = v0;
  assign b1.in1_valid = v1;
  assign b1.out_ready = ordy;
  stream_mux_2x1 #(.DATA_WIDTH(DW), .MAX_BURST(4)) u0 (.clk(clk), .rst_n(rst_n), .s(b0));
  stream_mux_2x1 #(.DATA_WIDTH(DW), .MAX_BURST(1)) u1 (.clk(clk), .rst_n(rst_n), .s(b1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // winner of this cycle: -1 none; a source keeps winning a contest until it has had mb beats in a row
  function automatic int winner(input int k);
    if (v0 && v1) return (run[k] >= mb[k]) ? 1 - last[k] : last[k];
    if (v1) return 1;
    if (v0) return 0;
    return -1;
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0; md[k] = 0; ms[k] = 0; last[k] = 1; run[k] = mb[k];
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int g;
      bit ld;
      ld = !mv[k] || ordy;
      g = winner(k);
      chk($sformatf("k%0d out_valid", k), k ? b1.out_valid : b0.out_valid, mv[k]);
      chk($sformatf("k%0d out0", k), k ? b1.out0 : b0.out0, md[k]);
      chk($sformatf("k%0d out_sel", k), k ? b1.out_sel : b0.out_sel, ms[k]);
      chk($sformatf("k%0d in0_ready", k), k ? b1.in0_ready : b0.in0_ready, ld && g == 0);
      chk($sformatf("k%0d in1_ready", k), k ? b1.in1_ready : b0.in1_ready, ld && g == 1);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    for (int k = 0; k < 2; k++) begin
      int g;
      g = winner(k);
      if (!mv[k] || ordy) begin
        if (g < 0) mv[k] = 0;
        else begin
          mv[k] = 1;
          md[k] = g ? int'(d1) : int'(d0);
          ms[k] = g;
          run[k] = (g == last[k]) ? run[k] + 1 : 1;
          last[k] = g;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    d0 = '0; d1 = '0; v0 = 0; v1 = 0; ordy = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    // contention with fixed data: groups of MAX_BURST
    d0 = 4'd3; d1 = 4'd9; v0 = 1; v1 = 1; ordy = 1;
    repeat (12) cycle();
    // lone requester on input 1 is never throttled
    v0 = 0;
    for (int i = 0; i < 10; i++) begin
      d1 = DW'(i + 1);
      cycle();
    end
    v1 = 0;
    cycle();
    // backpressure hold, then drain and refill in the same edge
    d0 = 4'd5; v0 = 1;
    cycle();
    ordy = 0; d0 = 4'd7; v1 = 1;
    repeat (3) cycle();
    ordy = 1;
    repeat (2) cycle();
    v0 = 0; v1 = 0;
    repeat (3) cycle();
    // out_ready toggling with both valid
    v0 = 1; v1 = 1;
    for (int i = 0; i < 12; i++) begin
      d0 = DW'($urandom); d1 = DW'($urandom);
      ordy = (i % 2 == 0);
      cycle();
    end
    // random traffic
    for (int i = 0; i < 400; i++) begin
      d0 = DW'($urandom); d1 = DW'($urandom);
      v0 = ($urandom_range(3) != 0); v1 = ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      cycle();
    end
    // asynchronous reset while a beat is held
    v0 = 1; v1 = 1; ordy = 0;
    cycle();
    chk("held_before_rst", b0.out_valid, 1);
    #2;
    rst_n = 1'b0;
    mreset();
    #1;
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_out0", b0.out0, 0);
    chk("rst_out_sel", b0.out_sel, 0);
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ordy = 1; d0 = 4'd2; d1 = 4'd4;
    cycle();
    chk("first_after_rst_sel", b0.out_sel, 0);
    chk("first_after_rst_sel_mb1", b1.out_sel, 0);
    repeat (6) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
